// File: rtl/multi_target_canvas.sv
// Multi-target duck canvas: composites cursor/grass/ducks/sky into a registered RGB stream
// and resolves mouse clicks against all live targets. Optional HIT_FLASH_EN whitens hit ducks.
module multi_target_canvas #(
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned COLOR_W     = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [3*COLOR_W-1:0] KEY_RGB = 12'h0FB,
  parameter logic [3*COLOR_W-1:0] SKY_RGB = 12'h6AF
) (
  input  logic                             pixel_clk,
  input  logic                             Reset,
  input  logic                             frame_tick,
  input  logic                             start,
  input  logic                             mouse_btn,
  input  logic [COORD_W-1:0]               cursor_x,
  input  logic [COORD_W-1:0]               cursor_y,
  input  logic [COORD_W-1:0]               cursor_size,
  input  logic [COORD_W-1:0]               draw_x,
  input  logic [COORD_W-1:0]               draw_y,
  input  logic                             blank,
  input  logic [NUM_TARGETS*COORD_W-1:0]   target_x,
  input  logic [NUM_TARGETS*COORD_W-1:0]   target_y,
  input  logic [NUM_TARGETS*COORD_W-1:0]   target_size,
  input  logic [NUM_TARGETS-1:0]           target_alive,
  input  logic [NUM_TARGETS*3*COLOR_W-1:0] sprite_rgb,
  input  logic [3*COLOR_W-1:0]             grass_rgb,
  output logic [COLOR_W-1:0]               red,
  output logic [COLOR_W-1:0]               green,
  output logic [COLOR_W-1:0]               blue,
  output logic [CNT_W-1:0]                 click_count,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [NUM_TARGETS-1:0]           kill,
  output logic                             miss
);

  localparam int unsigned RGB_W = 3 * COLOR_W;
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam int unsigned D2_W  = 2 * COORD_W + 2;
  localparam logic [RGB_W-1:0] CURSOR_RGB = {{COLOR_W{1'b1}}, COLOR_W'(2), COLOR_W'(2)};
  localparam logic [RGB_W-1:0] WHITE_RGB  = {RGB_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       click_nxt, hit_nxt;
  logic [NUM_TARGETS-1:0] kill_nxt;
  logic                   miss_nxt;
  logic [RGB_W-1:0]       pix_nxt;

  logic [NUM_TARGETS-1:0] cursor_hit_c, draw_in_c, target_sel_c, hit_sel_c;
  logic [RGB_W-1:0]       sprite_pix_c;

  // Per-target box tests, widened by one bit so corner+size cannot wrap
  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_tgt
    logic [EXT_W-1:0] tx, ty, tx_end, ty_end;
    logic [RGB_W-1:0] spr;
    assign tx     = {1'b0, target_x[g*COORD_W +: COORD_W]};
    assign ty     = {1'b0, target_y[g*COORD_W +: COORD_W]};
    assign tx_end = tx + {1'b0, target_size[g*COORD_W +: COORD_W]};
    assign ty_end = ty + {1'b0, target_size[g*COORD_W +: COORD_W]};
    assign spr    = sprite_rgb[g*RGB_W +: RGB_W];
    assign cursor_hit_c[g] = target_alive[g]
                             && ({1'b0, cursor_x} >= tx) && ({1'b0, cursor_x} <= tx_end)
                             && ({1'b0, cursor_y} >= ty) && ({1'b0, cursor_y} <= ty_end);
    assign draw_in_c[g]    = target_alive[g] && (spr != KEY_RGB)
                             && ({1'b0, draw_x} >= tx) && ({1'b0, draw_x} <= tx_end)
                             && ({1'b0, draw_y} >= ty) && ({1'b0, draw_y} <= ty_end);
  end

  // Lowest-index set bit wins for both the kill and the drawn sprite
  assign hit_sel_c    = cursor_hit_c & (~cursor_hit_c + NUM_TARGETS'(1));
  assign target_sel_c = draw_in_c & (~draw_in_c + NUM_TARGETS'(1));

  // Cursor ring geometry
  logic signed [EXT_W-1:0] dx_c, dy_c;
  logic signed [D2_W-1:0]  dxw_c, dyw_c, szw_c, d2_c, r2_c;
  logic                    cursor_on_c;

  assign dx_c  = $signed({1'b0, draw_x}) - $signed({1'b0, cursor_x});
  assign dy_c  = $signed({1'b0, draw_y}) - $signed({1'b0, cursor_y});
  assign dxw_c = D2_W'(dx_c);
  assign dyw_c = D2_W'(dy_c);
  assign szw_c = $signed(D2_W'(cursor_size));
  assign d2_c  = dxw_c * dxw_c + dyw_c * dyw_c;
  assign r2_c  = szw_c * szw_c;
  assign cursor_on_c = ((d2_c >= r2_c - D2_W'(2)) && (d2_c <= r2_c))
                       || (((dx_c == '0) || (dy_c == '0)) && (d2_c <= r2_c));

`ifdef HIT_FLASH_EN
  logic [2:0] flash_cnt [NUM_TARGETS];
  logic       flash_pix_c;
`endif

  // Sprite pixel of the selected target
  always_comb begin
    sprite_pix_c = '0;
`ifdef HIT_FLASH_EN
    flash_pix_c  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (target_sel_c[i]) begin
        sprite_pix_c = sprite_rgb[i*RGB_W +: RGB_W];
`ifdef HIT_FLASH_EN
        flash_pix_c  = (flash_cnt[i] != 3'd0);
`endif
      end
    end
  end

  // Layer priority: blank, cursor, grass, ducks, sky
  always_comb begin
    pix_nxt = SKY_RGB;
    if (!blank)                   pix_nxt = '0;
    else if (cursor_on_c)         pix_nxt = mouse_btn ? CURSOR_RGB : '0;
    else if (grass_rgb != KEY_RGB) pix_nxt = grass_rgb;
    else if (|target_sel_c) begin
`ifdef HIT_FLASH_EN
      pix_nxt = flash_pix_c ? WHITE_RGB : sprite_pix_c;
`else
      pix_nxt = sprite_pix_c;
`endif
    end
  end

  // Click FSM next state and registered-output next values
  always_comb begin
    state_nxt = state;
    click_nxt = click_count;
    hit_nxt   = hit_count;
    kill_nxt  = '0;
    miss_nxt  = 1'b0;
    if (!start) begin
      state_nxt = IDLE;
      click_nxt = '0;
      hit_nxt   = '0;
    end else if (frame_tick) begin
      case (state)
        IDLE:  state_nxt = ARMED;
        ARMED: begin
          if (mouse_btn) begin
            state_nxt = HELD;
            click_nxt = (click_count == '1) ? click_count : click_count + CNT_W'(1);
            if (|cursor_hit_c) begin
              kill_nxt = hit_sel_c;
              hit_nxt  = (hit_count == '1) ? hit_count : hit_count + CNT_W'(1);
            end else begin
              miss_nxt = 1'b1;
            end
          end
        end
        HELD:    if (!mouse_btn) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      state       <= IDLE;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      click_count <= '0;
      hit_count   <= '0;
      kill        <= '0;
      miss        <= 1'b0;
    end else begin
      state              <= state_nxt;
      {red, green, blue} <= pix_nxt;
      click_count        <= click_nxt;
      hit_count          <= hit_nxt;
      kill               <= kill_nxt;
      miss               <= miss_nxt;
    end
  end

`ifdef HIT_FLASH_EN
  // Flash timers: reload on kill, count down once per frame
  always_ff @(posedge pixel_clk) begin
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (Reset || !start)               flash_cnt[i] <= 3'd0;
      else if (kill_nxt[i])              flash_cnt[i] <= 3'd7;
      else if (frame_tick && flash_cnt[i] != 3'd0) flash_cnt[i] <= flash_cnt[i] - 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_target_canvas.sv
// Self-checking bench for multi_target_canvas: directed plan steps, then random stimulus
// against a behavioural model. Define HIT_FLASH_EN to cover the flash build.
module tb_multi_target_canvas;

  localparam int NT  = 2;
  localparam int CW  = 10;
  localparam int CLW = 4;
  localparam int CNW = 8;
  localparam logic [11:0] KEY = 12'h0FB;
  localparam logic [11:0] SKY = 12'h6AF;

  logic              pixel_clk = 1'b0;
  logic              Reset, frame_tick, start, mouse_btn, blank;
  logic [CW-1:0]     cursor_x, cursor_y, cursor_size, draw_x, draw_y;
  logic [NT*CW-1:0]  target_x, target_y, target_size;
  logic [NT-1:0]     target_alive;
  logic [NT*12-1:0]  sprite_rgb;
  logic [11:0]       grass_rgb;
  logic [CLW-1:0]    red, green, blue;
  logic [CNW-1:0]    click_count, hit_count;
  logic [NT-1:0]     kill;
  logic              miss;

  multi_target_canvas #(.NUM_TARGETS(NT), .COORD_W(CW), .COLOR_W(CLW), .CNT_W(CNW),
                        .KEY_RGB(KEY), .SKY_RGB(SKY)) dut (
    .pixel_clk(pixel_clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .mouse_btn(mouse_btn), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_size(cursor_size), .draw_x(draw_x), .draw_y(draw_y), .blank(blank),
    .target_x(target_x), .target_y(target_y), .target_size(target_size),
    .target_alive(target_alive), .sprite_rgb(sprite_rgb), .grass_rgb(grass_rgb),
    .red(red), .green(green), .blue(blue), .click_count(click_count),
    .hit_count(hit_count), .kill(kill), .miss(miss));

  always #5 pixel_clk = ~pixel_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: game running flag, button-latched flag, scores, flash timers
  bit m_run, m_held;
  int m_clicks, m_hits;
  int m_flash [NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit box_has(input int t, input int px, input int py);
    int tx, ty, ts;
    tx = int'(target_x[t*CW +: CW]);
    ty = int'(target_y[t*CW +: CW]);
    ts = int'(target_size[t*CW +: CW]);
    return target_alive[t] && px >= tx && px <= tx + ts && py >= ty && py <= ty + ts;
  endfunction

  function automatic logic [11:0] model_pix();
    int dx, dy, d2, r2;
    logic [11:0] spr;
    if (!blank) return 12'h000;
    dx = int'(draw_x) - int'(cursor_x);
    dy = int'(draw_y) - int'(cursor_y);
    d2 = dx * dx + dy * dy;
    r2 = int'(cursor_size) * int'(cursor_size);
    if ((d2 >= r2 - 2 && d2 <= r2) || ((dx == 0 || dy == 0) && d2 <= r2))
      return mouse_btn ? 12'hF22 : 12'h000;
    if (grass_rgb != KEY) return grass_rgb;
    for (int t = 0; t < NT; t++) begin
      spr = sprite_rgb[t*12 +: 12];
      if (box_has(t, int'(draw_x), int'(draw_y)) && spr != KEY) begin
`ifdef HIT_FLASH_EN
        if (m_flash[t] > 0) return 12'hFFF;
`endif
        return spr;
      end
    end
    return SKY;
  endfunction

  // One clock: predict from current inputs, clock, compare all outputs
  task automatic step();
    logic [11:0]   e_pix;
    logic [NT-1:0] e_kill;
    logic          e_miss;
    int            hit_t;
    e_pix  = model_pix();
    e_kill = '0;
    e_miss = 1'b0;
    if (Reset || !start) begin
      m_run = 0; m_held = 0; m_clicks = 0; m_hits = 0;
      for (int t = 0; t < NT; t++) m_flash[t] = 0;
      if (Reset) e_pix = 12'h000;
    end else if (frame_tick) begin
      for (int t = 0; t < NT; t++) if (m_flash[t] > 0) m_flash[t]--;
      if (!m_run) m_run = 1;
      else if (!m_held) begin
        if (mouse_btn) begin
          m_held = 1;
          if (m_clicks < 255) m_clicks++;
          hit_t = -1;
          for (int t = 0; t < NT; t++)
            if (hit_t < 0 && box_has(t, int'(cursor_x), int'(cursor_y))) hit_t = t;
          if (hit_t >= 0) begin
            e_kill[hit_t] = 1'b1;
            if (m_hits < 255) m_hits++;
            m_flash[hit_t] = 7;
          end else e_miss = 1'b1;
        end
      end else if (!mouse_btn) m_held = 0;
    end
    @(posedge pixel_clk); #1;
    chk("rgb", 32'({red, green, blue}), 32'(e_pix));
    chk("kill", 32'(kill), 32'(e_kill));
    chk("miss", 32'(miss), 32'(e_miss));
    chk("click_count", 32'(click_count), 32'(m_clicks));
    chk("hit_count", 32'(hit_count), 32'(m_hits));
  endtask

  task automatic tick(input logic btn);
    mouse_btn = btn; frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic set_tgt(input int t, input int x, input int y, input int s);
    target_x[t*CW +: CW]    = CW'(x);
    target_y[t*CW +: CW]    = CW'(y);
    target_size[t*CW +: CW] = CW'(s);
  endtask

  int hits_before;

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; mouse_btn = 1'b0; blank = 1'b0;
    cursor_x = '0; cursor_y = '0; cursor_size = CW'(3); draw_x = '0; draw_y = '0;
    target_x = '0; target_y = '0; target_size = '0; target_alive = '0;
    sprite_rgb = {NT{KEY}}; grass_rgb = KEY;
    step();
    chk("reset_rgb", 32'({red, green, blue}), 32'h0);
    chk("reset_clicks", 32'(click_count), 32'h0);
    Reset = 1'b0;

    // Single hit
    start = 1'b1; set_tgt(0, 100, 100, 20); set_tgt(1, 300, 50, 20); target_alive = 2'b11;
    tick(1'b0);
    cursor_x = 10'd110; cursor_y = 10'd105;
    tick(1'b1);
    chk("first_kill", 32'(kill), 32'h1);
    chk("first_hits", 32'(hit_count), 32'h1);
    step();
    chk("kill_one_cycle", 32'(kill), 32'h0);

    // Holding never re-counts; re-press does
    for (int k = 0; k < 5; k++) begin tick(1'b1); step(); end
    chk("held_clicks", 32'(click_count), 32'h1);
    tick(1'b0);
    tick(1'b1);
    chk("repress_clicks", 32'(click_count), 32'h2);
    tick(1'b0);

    // Overlapping boxes: one kill, lowest live index
    set_tgt(1, 100, 100, 20); cursor_x = 10'd105; cursor_y = 10'd105;
    hits_before = int'(hit_count);
    tick(1'b1);
    chk("overlap_kill", 32'(kill), 32'h1);
    chk("overlap_hits", 32'(hit_count), 32'(hits_before + 1));
    tick(1'b0);
    target_alive = 2'b10;
    tick(1'b1);
    chk("overlap_kill_t1", 32'(kill), 32'h2);
    tick(1'b0);

    // Miss and click saturation
    cursor_x = 10'd0; cursor_y = 10'd0; hits_before = int'(hit_count);
    tick(1'b1);
    chk("miss_pulse", 32'(miss), 32'h1);
    chk("miss_hits", 32'(hit_count), 32'(hits_before));
    for (int k = 0; k < 300; k++) begin tick(1'b0); tick(1'b1); end
    chk("click_sat", 32'(click_count), 32'd255);
    tick(1'b0);

    // Pixel priority
    blank = 1'b1; mouse_btn = 1'b1; target_alive = 2'b11;
    set_tgt(0, 100, 100, 20); set_tgt(1, 100, 100, 20);
    cursor_x = 10'd200; cursor_y = 10'd200; cursor_size = 10'd5;
    draw_x = 10'd200; draw_y = 10'd200;
    step(); chk("pix_cursor", 32'({red, green, blue}), 32'hF22);
    draw_x = 10'd110; draw_y = 10'd110; grass_rgb = 12'h123; sprite_rgb = {12'h456, 12'h789};
    step(); chk("pix_grass", 32'({red, green, blue}), 32'h123);
    grass_rgb = KEY;
    step(); chk("pix_sprite0", 32'({red, green, blue}), 32'h789);
    sprite_rgb = {NT{KEY}};
    step(); chk("pix_keyed", 32'({red, green, blue}), 32'h6AF);
    blank = 1'b0;
    step(); chk("pix_blank", 32'({red, green, blue}), 32'h000);
    blank = 1'b1;

    // start dropped while held
    tick(1'b1);
    start = 1'b0; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    chk("stop_clicks", 32'(click_count), 32'h0);
    chk("stop_kill", 32'(kill), 32'h0);
    start = 1'b1; tick(1'b1);
    chk("idle_no_count", 32'(click_count), 32'h0);

    // Kill then flash window (sprite unchanged when flash is not built)
    tick(1'b0);
    target_alive = 2'b01; set_tgt(0, 100, 100, 20);
    cursor_x = 10'd105; cursor_y = 10'd105; cursor_size = 10'd2;
    draw_x = 10'd115; draw_y = 10'd115; sprite_rgb = {KEY, 12'h345};
    tick(1'b1);
    chk("flash_kill", 32'(kill), 32'h1);
    step();
    for (int k = 0; k < 7; k++) begin
      tick(1'b1);
`ifdef HIT_FLASH_EN
      chk("flash_white", 32'({red, green, blue}), 32'hFFF);
`else
      chk("no_flash", 32'({red, green, blue}), 32'h345);
`endif
    end
    step();
    chk("flash_done", 32'({red, green, blue}), 32'h345);

    // Random phase against the model
    for (int c = 0; c < 2000; c++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 59) != 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) mouse_btn = ~mouse_btn;
      blank      = ($urandom_range(0, 9) != 0);
      cursor_x   = CW'($urandom_range(80, 150));
      cursor_y   = CW'($urandom_range(80, 150));
      cursor_size = CW'($urandom_range(0, 10));
      draw_x     = CW'($urandom_range(80, 150));
      draw_y     = CW'($urandom_range(80, 150));
      grass_rgb  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : KEY;
      if ($urandom_range(0, 15) == 0) begin
        for (int t = 0; t < NT; t++)
          set_tgt(t, $urandom_range(90, 130), $urandom_range(90, 130), $urandom_range(0, 30));
        target_alive = NT'($urandom);
      end
      for (int t = 0; t < NT; t++)
        sprite_rgb[t*12 +: 12] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
